// File: rtl/synth_pkg.sv
// Shared constants for the synth voice blocks: sequencer state encoding,
// default counter width and the shortest legal step.
package synth_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_t;

   localparam int CNT_W_DEF    = 8;
   localparam int MIN_STEP_LEN = 2;

endpackage : synth_pkg

// File: rtl/step_timer.sv
// Tick counter for one sequencer step. It reports the post-update count and a
// wrap flag when a tick lands on or past the last tick of the step.
module step_timer
   import synth_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             tick,
   input  logic             clear,
   input  logic [CNT_W-1:0] len,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] count_nxt,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nxt_s;
   logic             wrap_s;

   // Next count. Using >= lets a shortened step wrap on the next tick.
   always_comb begin
      wrap_s      = 1'b0;
      count_nxt_s = count_r;
      if (clear) begin
         count_nxt_s = '0;
      end else if (tick) begin
         if (count_r >= (len - ONE)) begin
            wrap_s      = 1'b1;
            count_nxt_s = '0;
         end else begin
            count_nxt_s = count_r + ONE;
         end
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_r <= '0;
      end else begin
         count_r <= count_nxt_s;
      end
   end

   assign count     = count_r;
   assign count_nxt = count_nxt_s;
   assign wrap      = wrap_s;

endmodule : step_timer

// File: rtl/gate_sequencer.sv
// Eight-step gate sequencer feeding adsr.trig: divides the tick strobe into
// steps and raises trig for a programmable length on each active step.
module gate_sequencer
   import synth_pkg::*;
#(
   parameter int STEPS_W = 3,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  tick,
   input  logic                  enable,
   input  logic [CNT_W-1:0]      step_len,
   input  logic [CNT_W-1:0]      gate_len,
   input  logic [2**STEPS_W-1:0] pattern,
   input  logic [STEPS_W-1:0]    last_step,
   output logic                  trig,
   output logic [STEPS_W-1:0]    step,
   output logic                  step_strobe,
   output logic                  running
);

   localparam logic [CNT_W-1:0]   ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]   MIN_LEN = CNT_W'(MIN_STEP_LEN);
   localparam logic [STEPS_W-1:0] STEP_1  = STEPS_W'(1);

   seq_state_t          state_r, state_nxt_s;
   logic [STEPS_W-1:0]  step_r, step_nxt_s;
   logic                trig_r, trig_nxt_s;
   logic                strobe_r, strobe_nxt_s;
   logic                running_r, running_nxt_s;
   logic [CNT_W-1:0]    eff_len_s;
   logic [CNT_W-1:0]    count_s, count_nxt_s;
   logic                wrap_s;
   logic                clear_s;

   // The last tick of a step is always low so the envelope sees a new attack.
   function automatic logic gate_on(input logic pat_bit, input logic [CNT_W-1:0] c,
                                    input logic [CNT_W-1:0] gl, input logic [CNT_W-1:0] l);
      return pat_bit && (c < gl) && (c < (l - ONE));
   endfunction

   assign eff_len_s = (step_len < MIN_LEN) ? MIN_LEN : step_len;
   assign clear_s   = (state_r == ST_IDLE) || !enable;

   step_timer #(.CNT_W(CNT_W)) u_timer (
      .clk       (clk),
      .rstn      (rstn),
      .tick      (tick),
      .clear     (clear_s),
      .len       (eff_len_s),
      .count     (count_s),
      .count_nxt (count_nxt_s),
      .wrap      (wrap_s)
   );

   // Next state, step index and gate
   always_comb begin
      state_nxt_s   = state_r;
      step_nxt_s    = step_r;
      trig_nxt_s    = trig_r;
      strobe_nxt_s  = 1'b0;
      running_nxt_s = running_r;
      case (state_r)
         ST_IDLE: begin
            if (enable) begin
               state_nxt_s   = ST_RUN;
               step_nxt_s    = '0;
               strobe_nxt_s  = 1'b1;
               running_nxt_s = 1'b1;
               trig_nxt_s    = gate_on(pattern[0], '0, gate_len, eff_len_s);
            end else begin
               step_nxt_s    = '0;
               trig_nxt_s    = 1'b0;
               running_nxt_s = 1'b0;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_nxt_s   = ST_IDLE;
               step_nxt_s    = '0;
               trig_nxt_s    = 1'b0;
               running_nxt_s = 1'b0;
            end else if (tick) begin
               if (wrap_s) begin
                  step_nxt_s = (step_r >= last_step) ? '0 : step_r + STEP_1;
               end else begin
                  step_nxt_s = step_r;
               end
               strobe_nxt_s = wrap_s;
               trig_nxt_s   = gate_on(pattern[step_nxt_s], count_nxt_s, gate_len, eff_len_s);
            end else begin
               trig_nxt_s = trig_r;
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            step_nxt_s    = '0;
            trig_nxt_s    = 1'b0;
            running_nxt_s = 1'b0;
         end
      endcase
   end

   // Output and state registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r   <= ST_IDLE;
         step_r    <= '0;
         trig_r    <= 1'b0;
         strobe_r  <= 1'b0;
         running_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         step_r    <= step_nxt_s;
         trig_r    <= trig_nxt_s;
         strobe_r  <= strobe_nxt_s;
         running_r <= running_nxt_s;
      end
   end

   assign trig        = trig_r;
   assign step        = step_r;
   assign step_strobe = strobe_r;
   assign running     = running_r;

endmodule : gate_sequencer
